// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: tracks frame position with an oversampling edge counter and
// bit counter, strobes the sampler/deserializer/checkers and flags clean frames.
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [3:0]                bit_cnt,
    output logic                      dat_samp_en,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic                      last_edge;
    logic                      samp_edge;

    assign last_edge = (edge_cnt_q == Prescale - PRESCALE_WIDTH'(1));
    // Majority sample spans P/2-1..P/2+1, so the sampled bit is settled two edges past mid-bit.
    assign samp_edge = (edge_cnt_q == (Prescale >> 1) + PRESCALE_WIDTH'(2));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        if (state_q != StIdle) begin
            if (last_edge) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (!RX_IN) state_d = StStart;
            end
            StStart: begin
                if (last_edge) state_d = strt_glitch ? StIdle : StData;
            end
            StData: begin
                if (last_edge && (bit_cnt_q == 4'(DATA_WIDTH))) begin
                    state_d = PAR_EN ? StParity : StStop;
                end
            end
            StParity: begin
                if (last_edge) state_d = par_err ? StIdle : StStop;
            end
            StStop: begin
                if (last_edge) state_d = RX_IN ? StIdle : StStart;
            end
            default: state_d = StIdle;
        endcase

        // Leaving a frame, or chaining straight into the next one, restarts both counters.
        if (state_d == StIdle || (state_q == StStop && state_d == StStart)) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end
    end

    always_comb begin
        dat_samp_en = (state_q != StIdle);
        strt_chk_en = (state_q == StStart)  && samp_edge;
        deser_en    = (state_q == StData)   && samp_edge;
        par_chk_en  = (state_q == StParity) && samp_edge;
        stp_chk_en  = (state_q == StStop)   && samp_edge;
        data_valid  = (state_q == StStop)   && last_edge && !stp_err;
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives whole frames on RX_IN and checks strobe timing,
// frame acceptance/rejection, back-to-back chaining and asynchronous reset.
module tb_uart_rx_fsm;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic       par_en;
    logic [5:0] prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;

    int tests_run = 0;
    int fails     = 0;
    int exp_s     = 6;

    // Monitor state, written only by the monitor below.
    int cyc = 0, deser_cnt = 0, deser_bad = 0, strt_cnt = 0, strt_edge = 0;
    int par_cnt = 0, par_bit = 0, par_edge = 0, stp_cnt = 0, stp_edge = 0;
    int dv_cnt = 0, dv_bit = 0, dv_edge = 0, dv_cyc_last = 0, dv_cyc_prev = 0;
    int samp_cnt = 0, mon_last_bit = 0, mon_last_edge = 0, idle_viol = 0;

    uart_rx_fsm #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .RX_IN      (rx_in),
        .PAR_EN     (par_en),
        .Prescale   (prescale),
        .strt_glitch(strt_glitch),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .dat_samp_en(dat_samp_en),
        .deser_en   (deser_en),
        .strt_chk_en(strt_chk_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dat_samp_en === 1'b1) begin
            samp_cnt      <= samp_cnt + 1;
            mon_last_bit  <= int'(bit_cnt);
            mon_last_edge <= int'(edge_cnt);
        end
        if (deser_en === 1'b1) begin
            deser_cnt <= deser_cnt + 1;
            if (int'(edge_cnt) != exp_s) deser_bad <= deser_bad + 1;
        end
        if (strt_chk_en === 1'b1) begin
            strt_cnt  <= strt_cnt + 1;
            strt_edge <= int'(edge_cnt);
        end
        if (par_chk_en === 1'b1) begin
            par_cnt  <= par_cnt + 1;
            par_bit  <= int'(bit_cnt);
            par_edge <= int'(edge_cnt);
        end
        if (stp_chk_en === 1'b1) begin
            stp_cnt  <= stp_cnt + 1;
            stp_edge <= int'(edge_cnt);
        end
        if (data_valid === 1'b1) begin
            dv_cnt      <= dv_cnt + 1;
            dv_bit      <= int'(bit_cnt);
            dv_edge     <= int'(edge_cnt);
            dv_cyc_prev <= dv_cyc_last;
            dv_cyc_last <= cyc;
        end
        if (dat_samp_en === 1'b0 &&
            (deser_en | strt_chk_en | par_chk_en | stp_chk_en | data_valid) === 1'b1)
            idle_viol <= idle_viol + 1;
    end

    // Inputs change 1 time unit after the rising edge; every task ends at that point.
    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input int p, input logic pe,
                              input logic pb);
        drive(1'b0, p);
        for (int b = 0; b < 8; b++) drive(data[b], p);
        if (pe) drive(pb, p);
        drive(1'b1, p);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (edge_cnt !== 6'd0) begin fails++;
            $display("FAIL reset_edge_cnt: got %0d expected 0", edge_cnt); end
        tests_run++; if (bit_cnt !== 4'd0) begin fails++;
            $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
        tests_run++;
        if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid} !== 6'b0)
        begin fails++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid});
        end
        rst_n = 1'b1;
        drive(1'b1, 3);
        tests_run++; if (dat_samp_en !== 1'b0) begin fails++;
            $display("FAIL idle_hold: dat_samp_en got %b expected 0", dat_samp_en); end
    endtask

    task automatic test_basic_p8;
        int d0, b0, v0, s0, n0, i0;
        prescale = 6'd8; par_en = 1'b0; exp_s = 6;
        d0 = deser_cnt; b0 = deser_bad; v0 = dv_cnt; s0 = stp_cnt; n0 = samp_cnt; i0 = idle_viol;
        send_frame(8'hA5, 8, 1'b0, 1'b0);
        drive(1'b1, 5);
        tests_run++; if (deser_cnt - d0 != 8) begin fails++;
            $display("FAIL p8_deser_count: got %0d expected 8", deser_cnt - d0); end
        tests_run++; if (deser_bad - b0 != 0) begin fails++;
            $display("FAIL p8_deser_edge: got %0d off-edge pulses expected 0", deser_bad - b0); end
        tests_run++; if (strt_edge != 6) begin fails++;
            $display("FAIL p8_strt_edge: got %0d expected 6", strt_edge); end
        tests_run++; if (stp_cnt - s0 != 1 || stp_edge != 6) begin fails++;
            $display("FAIL p8_stp_chk: got %0d pulses at edge %0d expected 1 at 6",
                     stp_cnt - s0, stp_edge); end
        tests_run++; if (dv_cnt - v0 != 1) begin fails++;
            $display("FAIL p8_dv_count: got %0d expected 1", dv_cnt - v0); end
        tests_run++; if (dv_bit != 9 || dv_edge != 7) begin fails++;
            $display("FAIL p8_dv_pos: got bit %0d edge %0d expected bit 9 edge 7",
                     dv_bit, dv_edge); end
        tests_run++; if (samp_cnt - n0 != 80 || mon_last_bit != 9) begin fails++;
            $display("FAIL p8_frame_len: got %0d cycles last bit %0d expected 80 and 9",
                     samp_cnt - n0, mon_last_bit); end
        tests_run++; if (dat_samp_en !== 1'b0 || bit_cnt !== 4'd0 || edge_cnt !== 6'd0)
        begin fails++;
            $display("FAIL p8_back_idle: got samp %b bit %0d edge %0d expected 0 0 0",
                     dat_samp_en, bit_cnt, edge_cnt); end
        tests_run++; if (idle_viol - i0 != 0) begin fails++;
            $display("FAIL p8_idle_strobe: got %0d expected 0", idle_viol - i0); end
    endtask

    task automatic test_parity_p16;
        int p0, v0, b0, n0;
        prescale = 6'd16; par_en = 1'b1; exp_s = 10; par_err = 1'b0;
        p0 = par_cnt; v0 = dv_cnt; b0 = deser_bad; n0 = samp_cnt;
        send_frame(8'h3C, 16, 1'b1, 1'b0);
        drive(1'b1, 5);
        tests_run++; if (par_cnt - p0 != 1 || par_bit != 9 || par_edge != 10) begin fails++;
            $display("FAIL p16_par_chk: got %0d pulses bit %0d edge %0d expected 1 9 10",
                     par_cnt - p0, par_bit, par_edge); end
        tests_run++; if (dv_cnt - v0 != 1 || dv_bit != 10 || dv_edge != 15) begin fails++;
            $display("FAIL p16_dv: got %0d pulses bit %0d edge %0d expected 1 10 15",
                     dv_cnt - v0, dv_bit, dv_edge); end
        tests_run++; if (deser_bad - b0 != 0 || samp_cnt - n0 != 176) begin fails++;
            $display("FAIL p16_frame: got off-edge %0d cycles %0d expected 0 176",
                     deser_bad - b0, samp_cnt - n0); end
    endtask

    task automatic test_parity_err;
        int v0, s0, n0;
        prescale = 6'd16; par_en = 1'b1; exp_s = 10; par_err = 1'b1;
        v0 = dv_cnt; s0 = stp_cnt; n0 = samp_cnt;
        send_frame(8'h3C, 16, 1'b1, 1'b1);
        drive(1'b1, 5);
        par_err = 1'b0;
        tests_run++; if (dv_cnt - v0 != 0) begin fails++;
            $display("FAIL perr_dv: got %0d expected 0", dv_cnt - v0); end
        tests_run++; if (mon_last_bit != 9 || mon_last_edge != 15 || samp_cnt - n0 != 160)
        begin fails++;
            $display("FAIL perr_exit: got bit %0d edge %0d cycles %0d expected 9 15 160",
                     mon_last_bit, mon_last_edge, samp_cnt - n0); end
        tests_run++; if (stp_cnt - s0 != 0) begin fails++;
            $display("FAIL perr_no_stop: got %0d expected 0", stp_cnt - s0); end
    endtask

    task automatic test_start_glitch;
        int d0, v0, s0, n0;
        prescale = 6'd32; par_en = 1'b0; exp_s = 18; strt_glitch = 1'b1;
        d0 = deser_cnt; v0 = dv_cnt; s0 = strt_cnt; n0 = samp_cnt;
        drive(1'b0, 10);
        drive(1'b1, 40);
        strt_glitch = 1'b0;
        tests_run++; if (strt_cnt - s0 != 1 || strt_edge != 18) begin fails++;
            $display("FAIL glitch_strt_chk: got %0d pulses edge %0d expected 1 18",
                     strt_cnt - s0, strt_edge); end
        tests_run++; if (mon_last_bit != 0 || mon_last_edge != 31 || samp_cnt - n0 != 32)
        begin fails++;
            $display("FAIL glitch_exit: got bit %0d edge %0d cycles %0d expected 0 31 32",
                     mon_last_bit, mon_last_edge, samp_cnt - n0); end
        tests_run++; if (deser_cnt - d0 != 0 || dv_cnt - v0 != 0) begin fails++;
            $display("FAIL glitch_no_data: got deser %0d dv %0d expected 0 0",
                     deser_cnt - d0, dv_cnt - v0); end
    endtask

    task automatic test_stop_err;
        int v0, s0, n0;
        prescale = 6'd8; par_en = 1'b0; exp_s = 6; stp_err = 1'b1;
        v0 = dv_cnt; s0 = stp_cnt; n0 = samp_cnt;
        send_frame(8'h0F, 8, 1'b0, 1'b0);
        drive(1'b1, 5);
        stp_err = 1'b0;
        tests_run++; if (stp_cnt - s0 != 1) begin fails++;
            $display("FAIL serr_stp_chk: got %0d expected 1", stp_cnt - s0); end
        tests_run++; if (dv_cnt - v0 != 0) begin fails++;
            $display("FAIL serr_dv: got %0d expected 0", dv_cnt - v0); end
        tests_run++; if (dat_samp_en !== 1'b0 || samp_cnt - n0 != 80) begin fails++;
            $display("FAIL serr_idle: got samp %b cycles %0d expected 0 80",
                     dat_samp_en, samp_cnt - n0); end
    endtask

    task automatic test_back_to_back;
        int v0, n0;
        prescale = 6'd8; par_en = 1'b0; exp_s = 6;
        v0 = dv_cnt; n0 = samp_cnt;
        send_frame(8'h55, 8, 1'b0, 1'b0);
        send_frame(8'hFF, 8, 1'b0, 1'b0);
        drive(1'b1, 5);
        tests_run++; if (dv_cnt - v0 != 2) begin fails++;
            $display("FAIL b2b_dv_count: got %0d expected 2", dv_cnt - v0); end
        tests_run++; if (dv_cyc_last - dv_cyc_prev != 80) begin fails++;
            $display("FAIL b2b_dv_spacing: got %0d expected 80", dv_cyc_last - dv_cyc_prev); end
        tests_run++; if (samp_cnt - n0 != 160) begin fails++;
            $display("FAIL b2b_no_idle_gap: got %0d expected 160", samp_cnt - n0); end
    endtask

    task automatic test_reset_mid_frame;
        int v0, d0;
        logic found;
        prescale = 6'd8; par_en = 1'b0; exp_s = 6;
        v0 = dv_cnt;
        found = 1'b0;
        drive(1'b0, 1);
        rx_in = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bit_cnt === 4'd4) found = 1'b1;
        end
        tests_run++; if (found !== 1'b1) begin fails++;
            $display("FAIL mid_reach_bit4: got %b expected 1", found); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
             data_valid} !== 16'h0) begin fails++;
            $display("FAIL mid_async_clear: got edge %0d bit %0d samp %b expected all 0",
                     edge_cnt, bit_cnt, dat_samp_en); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 3);
        tests_run++; if (dv_cnt - v0 != 0 || dat_samp_en !== 1'b0) begin fails++;
            $display("FAIL mid_abort: got dv %0d samp %b expected 0 0",
                     dv_cnt - v0, dat_samp_en); end
        v0 = dv_cnt; d0 = deser_cnt;
        send_frame(8'h96, 8, 1'b0, 1'b0);
        drive(1'b1, 5);
        tests_run++; if (dv_cnt - v0 != 1 || dv_bit != 9 || deser_cnt - d0 != 8) begin fails++;
            $display("FAIL mid_recover: got dv %0d bit %0d deser %0d expected 1 9 8",
                     dv_cnt - v0, dv_bit, deser_cnt - d0); end
    endtask

    initial begin
        test_reset;
        test_basic_p8;
        test_parity_p16;
        test_parity_err;
        test_start_glitch;
        test_stop_err;
        test_back_to_back;
        test_reset_mid_frame;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
